// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter that shares one single-port data memory
//            among NCORES requesters. One access at a time; each access runs
//            IDLE -> ACCESS (MEM_LAT cycles) -> DONE (one-cycle ACK pulse).
// Ports    : clk, rstn (async, active-low)
//            REQ_RD/REQ_WR [NCORES]     level requests, held until ACK
//            REQ_ADDR  [NCORES*AW]      slot i at [i*AW +: AW]
//            REQ_WDATA [NCORES*DW]      slot i at [i*DW +: DW]
//            ACK [NCORES]               one-hot completion pulse
//            RDATA, GRANT_ID, BUSY      status / read data to cores
//            MEM_ADDR, MEM_WDATA, MEM_RD, MEM_WR, MEM_RDATA   memory side
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int NCORES  = 4,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NCORES-1:0]    REQ_RD,
  input  logic [NCORES-1:0]    REQ_WR,
  input  logic [NCORES*AW-1:0] REQ_ADDR,
  input  logic [NCORES*DW-1:0] REQ_WDATA,
  output logic [NCORES-1:0]    ACK,
  output logic [DW-1:0]        RDATA,
  output logic [2:0]           GRANT_ID,
  output logic                 BUSY,
  output logic [AW-1:0]        MEM_ADDR,
  output logic [DW-1:0]        MEM_WDATA,
  output logic                 MEM_RD,
  output logic                 MEM_WR,
  input  logic [DW-1:0]        MEM_RDATA
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state, w_state_n;
  logic [2:0]        r_ptr;
  logic [CW-1:0]     r_lat_cnt;
  logic              r_op_wr;
  logic [2:0]        r_gid;
  logic [DW-1:0]     r_rdata;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;

  logic [NCORES-1:0]   w_reqv;
  logic [2*NCORES-1:0] w_dbl;
  logic [NCORES-1:0]   w_rot;
  logic                w_found;
  logic [2:0]          w_sel;
  logic [AW-1:0]       w_addr;
  logic [DW-1:0]       w_wdata;
  logic                w_wr;

  // (a + b) mod NCORES for small b, with a already in range.
  function automatic logic [2:0] wrap_add(input logic [2:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NCORES) s = s - NCORES;
    return 3'(s);
  endfunction

  // Rotate the request vector so bit k is slot (ptr+k); the lowest set bit
  // of the rotated vector is the round-robin winner.
  always_comb begin
    w_reqv  = REQ_RD | REQ_WR;
    w_dbl   = {w_reqv, w_reqv};
    w_rot   = NCORES'(w_dbl >> r_ptr);
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_sel   = wrap_add(r_ptr, k);
      end
    end
    w_addr  = '0;
    w_wdata = '0;
    w_wr    = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (w_sel == 3'(i)) begin
        w_addr  = REQ_ADDR[i*AW +: AW];
        w_wdata = REQ_WDATA[i*DW +: DW];
        w_wr    = REQ_WR[i];  // write wins when both strobes are set
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_n = S_ACCESS;
      S_ACCESS: if (r_lat_cnt == '0) w_state_n = S_DONE;
      S_DONE:   w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
    ACK = '0;
    for (int i = 0; i < NCORES; i++) begin
      ACK[i] = (r_state == S_DONE) && (r_gid == 3'(i));
    end
    BUSY   = (r_state != S_IDLE);
    // Strobes decode straight from state so an async reset drops them at once.
    MEM_RD = (r_state == S_ACCESS) && !r_op_wr;
    MEM_WR = (r_state == S_ACCESS) &&  r_op_wr;
  end

  // Datapath: latched access, latency counter, read data, round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr     <= '0;
      r_lat_cnt <= '0;
      r_op_wr   <= 1'b0;
      r_gid     <= '0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_op_wr   <= w_wr;
            r_gid     <= w_sel;
            r_lat_cnt <= CW'(MEM_LAT - 1);
          end
        end
        S_ACCESS: begin
          if (r_lat_cnt == '0) begin
            if (!r_op_wr) r_rdata <= MEM_RDATA;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        S_DONE: r_ptr <= wrap_add(r_gid, 1);
        default: ;
      endcase
    end
  end

  assign RDATA     = r_rdata;
  assign GRANT_ID  = r_gid;
  assign MEM_ADDR  = r_addr;
  assign MEM_WDATA = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter (NCORES=4,
//            AW=DW=16, MEM_LAT=2). Inputs change and outputs are checked
//            1 time unit after each rising clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_rd, req_wr;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  ack;
  logic [15:0] rdata;
  logic [2:0]  grant_id;
  logic        busy;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NCORES(4), .AW(16), .DW(16), .MEM_LAT(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .REQ_RD    (req_rd),
    .REQ_WR    (req_wr),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
    .ACK       (ack),
    .RDATA     (rdata),
    .GRANT_ID  (grant_id),
    .BUSY      (busy),
    .MEM_ADDR  (mem_addr),
    .MEM_WDATA (mem_wdata),
    .MEM_RD    (mem_rd),
    .MEM_WR    (mem_wr),
    .MEM_RDATA (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset with random requests ----------------
    rstn      = 1'b0;
    req_rd    = 4'($urandom);
    req_wr    = 4'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    mem_rdata = 16'h5A5A;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      req_rd = 4'($urandom);
      req_wr = 4'($urandom);
    end
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_mwdata", 32'(mem_wdata), 32'h0);
    chk("rst_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
    req_rd = 4'h0;
    req_wr = 4'h0;
    rstn   = 1'b1;
    tick();
    chk("idle_busy0", 32'(busy), 32'h0);
    tick();
    chk("idle_busy1", 32'(busy), 32'h0);
    chk("idle_strobes", {30'h0, mem_rd, mem_wr}, 32'h0);

    // ---------------- single read, core 1 ----------------
    req_addr[1*16 +: 16] = 16'h0040;
    mem_rdata            = 16'hBEEF;
    req_rd               = 4'b0010;
    tick();  // grant
    chk("rd_acc1_mrd", 32'(mem_rd), 32'h1);
    chk("rd_acc1_maddr", 32'(mem_addr), 32'h0040);
    chk("rd_acc1_gid", 32'(grant_id), 32'h1);
    chk("rd_acc1_busy", 32'(busy), 32'h1);
    chk("rd_acc1_ack", 32'(ack), 32'h0);
    req_addr[1*16 +: 16] = 16'h7777;  // post-grant change must not matter
    tick();
    chk("rd_acc2_mrd", 32'(mem_rd), 32'h1);
    chk("rd_acc2_maddr", 32'(mem_addr), 32'h0040);
    tick();  // DONE
    chk("rd_done_ack", 32'(ack), 32'h2);
    chk("rd_done_rdata", 32'(rdata), 32'hBEEF);
    chk("rd_done_mrd", 32'(mem_rd), 32'h0);
    req_rd = 4'b0000;
    tick();
    chk("rd_idle_ack", 32'(ack), 32'h0);
    chk("rd_idle_busy", 32'(busy), 32'h0);

    // ---------------- single write, core 3 ----------------
    req_addr[3*16 +: 16]  = 16'h00FF;
    req_wdata[3*16 +: 16] = 16'h1234;
    mem_rdata             = 16'hDEAD;
    req_wr                = 4'b1000;
    tick();
    chk("wr_acc1_mwr", 32'(mem_wr), 32'h1);
    chk("wr_acc1_mrd", 32'(mem_rd), 32'h0);
    chk("wr_acc1_mwdata", 32'(mem_wdata), 32'h1234);
    chk("wr_acc1_maddr", 32'(mem_addr), 32'h00FF);
    chk("wr_acc1_gid", 32'(grant_id), 32'h3);
    tick();
    chk("wr_acc2_mwr", 32'(mem_wr), 32'h1);
    tick();
    chk("wr_done_ack", 32'(ack), 32'h8);
    chk("wr_done_rdata", 32'(rdata), 32'hBEEF);
    chk("wr_done_mwr", 32'(mem_wr), 32'h0);
    req_wr = 4'b0000;
    tick();
    chk("wr_idle_busy", 32'(busy), 32'h0);

    // ---------------- wrap: cores 0 and 2 after core 3 ----------------
    req_addr[0*16 +: 16] = 16'h0100;
    req_addr[2*16 +: 16] = 16'h0200;
    mem_rdata            = 16'h0A0A;
    req_rd               = 4'b0101;
    tick();
    chk("wrap_gid_first", 32'(grant_id), 32'h0);
    chk("wrap_maddr_first", 32'(mem_addr), 32'h0100);
    tick();
    tick();
    chk("wrap_ack_first", 32'(ack), 32'h1);
    chk("wrap_rdata_first", 32'(rdata), 32'h0A0A);
    req_rd    = 4'b0100;
    mem_rdata = 16'h0C0C;
    tick();  // mandatory IDLE cycle
    chk("wrap_idle_busy", 32'(busy), 32'h0);
    tick();
    chk("wrap_gid_second", 32'(grant_id), 32'h2);
    chk("wrap_maddr_second", 32'(mem_addr), 32'h0200);
    tick();
    tick();
    chk("wrap_ack_second", 32'(ack), 32'h4);
    chk("wrap_rdata_second", 32'(rdata), 32'h0C0C);
    req_rd = 4'b0000;
    tick();

    // ---------------- contention: all four, pointer starts at 3 ----------------
    req_rd = 4'b1111;
    begin
      logic [2:0] exp_ids [8] = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};
      logic [3:0] exp_ack [8] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
      for (int n = 0; n < 8; n++) begin
        tick();
        chk($sformatf("rr_gid_%0d", n), 32'(grant_id), 32'(exp_ids[n]));
        chk($sformatf("rr_busy_%0d", n), 32'(busy), 32'h1);
        tick();
        chk($sformatf("rr_noack_%0d", n), 32'(ack), 32'h0);
        tick();
        chk($sformatf("rr_ack_%0d", n), 32'(ack), 32'(exp_ack[n]));
        if (n == 7) req_rd = 4'b0000;
        tick();
        chk($sformatf("rr_idle_%0d", n), 32'(busy), 32'h0);
      end
    end

    // ---------------- reset mid-access of a core-2 read ----------------
    mem_rdata = 16'h3C3C;
    req_rd    = 4'b0100;
    tick();
    chk("mid_gid", 32'(grant_id), 32'h2);
    chk("mid_mrd", 32'(mem_rd), 32'h1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_mrd", 32'(mem_rd), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_gid", 32'(grant_id), 32'h0);
    chk("mid_rst_maddr", 32'(mem_addr), 32'h0);
    chk("mid_rst_rdata", 32'(rdata), 32'h0);
    for (int c = 0; c < 3; c++) begin
      req_rd = 4'($urandom) | 4'b0100;
      tick();
      chk("mid_rst_ack", 32'(ack), 32'h0);
    end
    // Cores 2 and 3 pending: restored pointer 0 must favour core 2.
    req_rd = 4'b1100;
    req_wr = 4'b0000;
    rstn   = 1'b1;
    tick();
    chk("post_gid", 32'(grant_id), 32'h2);
    chk("post_maddr", 32'(mem_addr), 32'h0200);
    tick();
    chk("post_noack", 32'(ack), 32'h0);
    tick();
    chk("post_ack", 32'(ack), 32'h4);
    chk("post_rdata", 32'(rdata), 32'h3C3C);
    req_rd = 4'b0000;
    tick();
    chk("post_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
